// File: rtl/rv32i_hazard_unit.sv
// Hazard control for the 5-stage RV32I pipeline: load-use stalls,
// branch/jump flushes and a reset flush window.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   regwriteE            instruction class of the op in Execute
//   Rs1D, Rs2D           source registers of the op in Decode
//   RdE                  destination register of the op in Execute
//   RdM                  destination register in Memory (not used)
//   PCSrcE               taken branch/jump resolved in Execute
//   stallF, stallD       hold the PC and F/D registers
//   flushF, flushD       clear Fetch and the F/D register
//   flushE               clear the D/E register

package rv32i_pkg;

    localparam int ADW = 5;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE_ALU,
        I_TYPE_LOAD,
        S_TYPE,
        B_TYPE,
        JAL,
        JALR,
        U_TYPE
    } instr_type_t;

endpackage

module rv32i_hazard_unit
    import rv32i_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  instr_type_t    regwriteE,
    input  logic [ADW-1:0] Rs1D,
    input  logic [ADW-1:0] Rs2D,
    input  logic [ADW-1:0] RdE,
    input  logic [ADW-1:0] RdM,
    input  logic           PCSrcE,
    output logic           stallF,
    output logic           flushF,
    output logic           stallD,
    output logic           flushD,
    output logic           flushE
);

    logic rstQ;
    logic inReset;
    logic isLoad;
    logic lwStall;
    logic doFlushAll;
    logic doBranch;
    logic doLoadUse;

    // A Memory-stage load is covered by forwarding; RdM is kept only
    // so the port list matches the rest of the core.
    logic unusedRdM;
    assign unusedRdM = ^RdM;

    // Stretches the flush window one cycle past reset release.
    always_ff @(posedge clk) begin
        rstQ <= rst;
    end

    assign inReset = rst | rstQ;

    // Decoded through a case so that X or unlisted values land on the
    // default and read as non-load.
    always_comb begin
        isLoad = 1'b0;
        case (regwriteE)
            I_TYPE_LOAD: isLoad = 1'b1;
            default:     isLoad = 1'b0;
        endcase
    end

    assign lwStall = isLoad
                   && (RdE != '0)
                   && ((Rs1D == RdE) || (Rs2D == RdE));

    // Mutually exclusive selects: reset beats redirect, which beats
    // load-use (the stalled Decode op would be discarded anyway).
    assign doFlushAll = inReset;
    assign doBranch   = !inReset && PCSrcE;
    assign doLoadUse  = !inReset && !PCSrcE && lwStall;

    always_comb begin
        stallF = 1'b0;
        flushF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        unique case (1'b1)
            doFlushAll: begin
                flushF = 1'b1;
                flushD = 1'b1;
                flushE = 1'b1;
            end
            doBranch: begin
                flushD = 1'b1;
                flushE = 1'b1;
            end
            doLoadUse: begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
            default: begin
                stallF = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// Self-checking bench for rv32i_hazard_unit: directed scenarios plus
// randomized traffic against a behavioural model.

module tb_rv32i_hazard_unit;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    instr_type_t regwriteE;
    logic [4:0]  Rs1D, Rs2D, RdE, RdM;
    logic        PCSrcE;
    logic        stallF, flushF, stallD, flushD, flushE;

    int errors = 0;
    int checks = 0;

    // Model state: was rst high at the most recent rising edge.
    bit mRstPrev = 1'b1;

    always #5 clk = ~clk;

    rv32i_hazard_unit dut (
        .clk       (clk),
        .rst       (rst),
        .regwriteE (regwriteE),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdE       (RdE),
        .RdM       (RdM),
        .PCSrcE    (PCSrcE),
        .stallF    (stallF),
        .flushF    (flushF),
        .stallD    (stallD),
        .flushD    (flushD),
        .flushE    (flushE)
    );

    // Vector order: {stallF, stallD, flushF, flushD, flushE}
    task automatic checkEq(input string tag,
                           input logic [4:0] got,
                           input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model(input bit r,
                                         input bit rPrev,
                                         input instr_type_t cls,
                                         input logic [4:0] s1,
                                         input logic [4:0] s2,
                                         input logic [4:0] dE,
                                         input bit br);
        bit hazard;
        if (r || rPrev) return 5'b00111;
        if (br) return 5'b00011;
        hazard = (cls == I_TYPE_LOAD) && (dE != 0)
               && (s1 == dE || s2 == dE);
        if (hazard) return 5'b11001;
        return 5'b00000;
    endfunction

    // Apply inputs mid-cycle, compare, then account for the next edge.
    task automatic step(input string tag,
                        input bit r,
                        input instr_type_t cls,
                        input logic [4:0] s1,
                        input logic [4:0] s2,
                        input logic [4:0] dE,
                        input logic [4:0] dM,
                        input bit br,
                        input logic [4:0] exp);
        @(negedge clk);
        rst       = r;
        regwriteE = cls;
        Rs1D      = s1;
        Rs2D      = s2;
        RdE       = dE;
        RdM       = dM;
        PCSrcE    = br;
        #1;
        checkEq(tag, {stallF, stallD, flushF, flushD, flushE}, exp);
        mRstPrev = r;
    endtask

    initial begin
        rst       = 1'b1;
        regwriteE = R_TYPE;
        Rs1D      = '0;
        Rs2D      = '0;
        RdE       = '0;
        RdM       = '0;
        PCSrcE    = 1'b0;

        step("rst0",   1, R_TYPE, 0, 0, 0, 0, 0, 5'b00111);
        step("rst1",   1, R_TYPE, 0, 0, 0, 0, 0, 5'b00111);
        step("rstQ",   0, R_TYPE, 0, 0, 0, 0, 0, 5'b00111);
        step("idle",   0, R_TYPE, 0, 0, 0, 0, 0, 5'b00000);

        for (int i = 0; i < 4; i++)
            step("brS",  0, S_TYPE, 2, 3, 2, 0, 1, 5'b00011);

        step("luRs1",  0, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b11001);
        step("luRs2",  0, I_TYPE_LOAD, 4, 2, 2, 0, 0, 5'b11001);
        step("memLd",  0, I_TYPE_LOAD, 5, 3, 7, 5, 0, 5'b00000);
        step("rdX0",   0, I_TYPE_LOAD, 0, 0, 0, 0, 0, 5'b00000);
        step("simul",  0, I_TYPE_LOAD, 6, 6, 6, 0, 1, 5'b00011);
        step("rtype",  0, R_TYPE, 6, 6, 6, 0, 0, 5'b00000);

        step("clsLd",  0, I_TYPE_LOAD, 9, 1, 9, 0, 0, 5'b11001);
        step("clsS",   0, S_TYPE, 9, 1, 9, 0, 0, 5'b00000);
        step("stall",  0, I_TYPE_LOAD, 9, 1, 9, 0, 0, 5'b11001);
        step("rstMid", 1, I_TYPE_LOAD, 9, 1, 9, 0, 0, 5'b00111);
        step("rstEnd", 0, I_TYPE_LOAD, 9, 1, 9, 0, 0, 5'b00111);
        step("resume", 0, I_TYPE_LOAD, 9, 1, 9, 0, 0, 5'b11001);

        for (int i = 0; i < 400; i++) begin
            bit          r, br;
            instr_type_t cls;
            logic [4:0]  s1, s2, dE, dM;
            r   = ($urandom_range(0, 19) == 0);
            br  = ($urandom_range(0, 3) == 0);
            cls = instr_type_t'(3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) cls = I_TYPE_LOAD;
            s1  = 5'($urandom_range(0, 5));
            s2  = 5'($urandom_range(0, 5));
            dE  = 5'($urandom_range(0, 5));
            dM  = 5'($urandom);
            step("rand", r, cls, s1, s2, dE, dM, br,
                 model(r, mRstPrev, cls, s1, s2, dE, br));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
